int_coalesce_manager: RTL and testbench

Multi-channel successor to the single read/write interrupt manager. Captures rising-edge done pulses from NUM_CH request channels and applies per-channel masks. Coalesces events by count threshold or timeout, then drives the PCIe core interrupt handshake in MSI or legacy INTx mode. Sits between the request/completion engines and the core cfg_interrupt interface; events are never dropped, only batched.

---
 rtl/int_coalesce_manager.sv | 152 +++++++++++++++
 tb/tb_int_coalesce_manager.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_coalesce_manager.sv
// Multi-channel interrupt coalescer: detects done edges, batches them by count or timeout,
// and drives the PCIe core cfg_interrupt handshake in MSI or legacy INTx mode.
module int_coalesce_manager #(
    parameter int NUM_CH = 4,
    parameter int COAL_W = 8,
    parameter int TMR_W  = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              int_en,
    input  logic [NUM_CH-1:0] int_msk_i,
    input  logic [NUM_CH-1:0] req_done_i,
    input  logic [COAL_W-1:0] coal_thresh_i,
    input  logic [TMR_W-1:0]  coal_timeout_i,
    output logic [NUM_CH-1:0] int_status_o,
    input  logic [NUM_CH-1:0] int_status_clr_i,
    output logic [CNT_W-1:0]  int_cnt_o,
    input  logic              msi_on,
    output logic              cfg_interrupt_n_o,
    input  logic              cfg_interrupt_rdy_n_i,
    output logic              cfg_interrupt_assert_n_o,
    input  logic              cfg_interrupt_legacyclr
);

    // Sum width must hold both a saturated batch count and a full popcount.
    localparam int SUM_W = ((COAL_W > 5) ? COAL_W : 5) + 1;
    localparam logic [COAL_W-1:0] BATCH_MAX = '1;
    localparam logic [TMR_W-1:0]  TMR_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE,
        MSI_REQ,
        ASSERT_REQ,
        ASSERTED,
        DEASSERT_REQ
    } state_t;

    state_t state, state_next;

    logic [NUM_CH-1:0] prev;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] events;
    logic [COAL_W-1:0] batch_cnt;
    logic [COAL_W-1:0] batch_next;
    logic [COAL_W-1:0] thresh_eff;
    logic [TMR_W-1:0]  timer;
    logic [SUM_W-1:0]  ev_cnt;
    logic [SUM_W-1:0]  batch_sum;
    logic              fire;

    assign events     = ~prev & req_done_i & ~int_msk_i & {NUM_CH{int_en & en}};
    assign thresh_eff = (coal_thresh_i == '0) ? COAL_W'(1) : coal_thresh_i;

    assign fire = (state == IDLE) && en && int_en && (batch_cnt != '0) &&
                  ((batch_cnt >= thresh_eff) ||
                   ((coal_timeout_i != '0) && (timer >= coal_timeout_i)));

    // Events arriving in a fire cycle start the next batch rather than joining the fired one.
    always_comb begin
        ev_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ev_cnt = ev_cnt + SUM_W'(events[i]);
        end
        batch_sum  = (fire ? '0 : SUM_W'(batch_cnt)) + ev_cnt;
        batch_next = (batch_sum > SUM_W'(BATCH_MAX)) ? BATCH_MAX : batch_sum[COAL_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev         <= '0;
            pend         <= '0;
            batch_cnt    <= '0;
            timer        <= '0;
            int_status_o <= '0;
            int_cnt_o    <= '0;
            state        <= IDLE;
        end else begin
            prev  <= req_done_i;
            state <= state_next;

            if (!en || !int_en) begin
                pend      <= '0;
                batch_cnt <= '0;
                timer     <= '0;
            end else begin
                pend      <= (fire ? '0 : pend) | events;
                batch_cnt <= batch_next;
                if (fire || (batch_cnt == '0)) begin
                    timer <= '0;
                end else if (timer != TMR_MAX) begin
                    timer <= timer + TMR_W'(1);
                end
            end

            // A fire setting a bit wins over a simultaneous host clear of that bit.
            if (!en) begin
                int_status_o <= '0;
            end else begin
                int_status_o <= (int_status_o & ~int_status_clr_i) | (fire ? pend : '0);
            end

            if (fire) begin
                int_cnt_o <= int_cnt_o + CNT_W'(1);
            end
        end
    end

    // Every request state is left only on a core accept, so no request is ever abandoned.
    always_comb begin
        state_next               = state;
        cfg_interrupt_n_o        = 1'b1;
        cfg_interrupt_assert_n_o = 1'b1;
        case (state)
            IDLE: begin
                if (fire) begin
                    state_next = msi_on ? MSI_REQ : ASSERT_REQ;
                end
            end
            MSI_REQ: begin
                cfg_interrupt_n_o = 1'b0;
                if (!cfg_interrupt_rdy_n_i) begin
                    state_next = IDLE;
                end
            end
            ASSERT_REQ: begin
                cfg_interrupt_n_o        = 1'b0;
                cfg_interrupt_assert_n_o = 1'b0;
                if (!cfg_interrupt_rdy_n_i) begin
                    state_next = ASSERTED;
                end
            end
            ASSERTED: begin
                cfg_interrupt_assert_n_o = 1'b0;
                if (!en || (int_status_o == '0) || cfg_interrupt_legacyclr) begin
                    state_next = DEASSERT_REQ;
                end
            end
            DEASSERT_REQ: begin
                cfg_interrupt_n_o = 1'b0;
                if (!cfg_interrupt_rdy_n_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_int_coalesce_manager.sv
// Scoreboard bench for int_coalesce_manager: directed scenarios plus randomized MSI traffic
// checked against a timestamp/count reference model.
module tb_int_coalesce_manager;

    localparam int NUM_CH = 4;
    localparam int COAL_W = 8;
    localparam int TMR_W  = 16;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              int_en;
    logic [NUM_CH-1:0] int_msk;
    logic [NUM_CH-1:0] req_done;
    logic [COAL_W-1:0] coal_thresh;
    logic [TMR_W-1:0]  coal_timeout;
    logic [NUM_CH-1:0] int_status;
    logic [NUM_CH-1:0] int_status_clr;
    logic [CNT_W-1:0]  int_cnt;
    logic              msi_on;
    logic              cfg_n;
    logic              rdy_n;
    logic              assert_n;
    logic              legacyclr;

    always #5 clk = ~clk;

    int_coalesce_manager #(
        .NUM_CH(NUM_CH),
        .COAL_W(COAL_W),
        .TMR_W (TMR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .en                      (en),
        .int_en                  (int_en),
        .int_msk_i               (int_msk),
        .req_done_i              (req_done),
        .coal_thresh_i           (coal_thresh),
        .coal_timeout_i          (coal_timeout),
        .int_status_o            (int_status),
        .int_status_clr_i        (int_status_clr),
        .int_cnt_o               (int_cnt),
        .msi_on                  (msi_on),
        .cfg_interrupt_n_o       (cfg_n),
        .cfg_interrupt_rdy_n_i   (rdy_n),
        .cfg_interrupt_assert_n_o(assert_n),
        .cfg_interrupt_legacyclr (legacyclr)
    );

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [NUM_CH-1:0] status;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    bit   sb_on = 1'b1;

    // Reference model: a batch is a set of pending channels, an event count and the
    // cycle its first event arrived; an MSI request is outstanding until the core accepts.
    bit [NUM_CH-1:0] m_prev;
    bit [NUM_CH-1:0] m_pend;
    bit [NUM_CH-1:0] m_status;
    int              m_count;
    int              m_first;
    bit              m_req;
    int unsigned     m_cnt;
    int              cyc = 0;

    task automatic check_output(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic model_step();
        bit [NUM_CH-1:0] ev;
        bit              fire_now;
        int              thr;
        exp_t            e;
        if (rst) begin
            m_prev = '0; m_pend = '0; m_status = '0;
            m_count = 0; m_first = 0; m_req = 1'b0; m_cnt = 0;
            return;
        end
        ev = ~m_prev & req_done & ~int_msk & ((en && int_en) ? '1 : '0);
        m_prev = req_done;
        if (!sb_on) return;
        thr = (coal_thresh == 0) ? 1 : int'(coal_thresh);
        fire_now = !m_req && en && int_en && (m_count > 0) &&
                   ((m_count >= thr) ||
                    ((coal_timeout != 0) && ((cyc - m_first - 1) >= int'(coal_timeout))));
        if (!en) m_status = '0;
        else     m_status = (m_status & ~int_status_clr) | (fire_now ? m_pend : '0);
        if (fire_now) begin
            m_cnt++;
            e.status = m_status;
            e.cnt    = m_cnt;
            sb_q.push_back(e);
            m_req = 1'b1;
        end else if (m_req && !rdy_n) begin
            m_req = 1'b0;
        end
        if (!en || !int_en) begin
            m_pend = '0;
            m_count = 0;
        end else begin
            if (fire_now) begin
                m_pend = '0;
                m_count = 0;
            end
            if (m_count == 0 && ev != 0) m_first = cyc;
            m_pend |= ev;
            m_count += $countones(ev);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_done = '0; int_status_clr = '0; rdy_n = 1'b1; legacyclr = 1'b0;
        en = 1'b1; int_en = 1'b1; int_msk = '0;
        cycle();
        cycle();
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic apply_stimulus();
        req_done       = NUM_CH'($urandom);
        rdy_n          = ($urandom_range(0, 3) != 0);
        int_status_clr = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
        int_en         = ($urandom_range(0, 31) != 0);
    endtask

    // Monitor: pops an expectation at each new request and polices the accept rule.
    logic prev_cfg = 1'b1;
    logic seen     = 1'b0;
    logic prev_rst = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (!prev_rst && !prev_cfg && cfg_n) check_output("rise_without_rdy", seen, 1);
        if (sb_on && prev_cfg && !cfg_n) begin
            if (sb_q.size() == 0) begin
                total++;
                $display("[TB] FAIL unexpected_request: got request at int_cnt_o=%0d, expected none", int_cnt);
            end else begin
                e = sb_q.pop_front();
                check_output("sb_status", int_status, e.status);
                check_output("sb_cnt", int_cnt, e.cnt);
            end
        end
        seen     = !cfg_n ? (seen | !rdy_n) : 1'b0;
        prev_cfg = cfg_n;
        prev_rst = rst;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b1; int_en = 1'b1; int_msk = '0; req_done = '0;
        coal_thresh = 8'd1; coal_timeout = '0; int_status_clr = '0;
        msi_on = 1'b1; rdy_n = 1'b1; legacyclr = 1'b0;
        @(posedge clk); #1;

        do_reset();
        check_output("reset_status", int_status, 0);
        check_output("reset_cnt", int_cnt, 0);
        check_output("reset_cfg_n", cfg_n, 1);
        check_output("reset_assert_n", assert_n, 1);

        // MSI single event, threshold 1
        req_done = 4'b0100; cycle();
        req_done = '0;
        check_output("msi_not_yet", cfg_n, 1);
        cycle();
        check_output("msi_req_low", cfg_n, 0);
        cycle(); cycle();
        check_output("msi_held", cfg_n, 0);
        rdy_n = 1'b0; cycle(); rdy_n = 1'b1;
        check_output("msi_released", cfg_n, 1);
        check_output("msi_status", int_status, 4'b0100);
        check_output("msi_cnt", int_cnt, 1);

        // Threshold 3: two events together, the third five cycles later
        do_reset();
        coal_thresh = 8'd3;
        req_done = 4'b0011; cycle();
        req_done = '0;
        repeat (4) cycle();
        check_output("thr_no_early", cfg_n, 1);
        req_done = 4'b1000; cycle();
        req_done = '0;
        check_output("thr_fire_cycle", cfg_n, 1);
        cycle();
        check_output("thr_req_low", cfg_n, 0);
        check_output("thr_status", int_status, 4'b1011);
        check_output("thr_cnt", int_cnt, 1);
        rdy_n = 1'b0; cycle(); rdy_n = 1'b1;

        // Timeout 20 with an unreachable threshold
        do_reset();
        coal_thresh = 8'd8; coal_timeout = 16'd20;
        req_done = 4'b0010; cycle();
        req_done = '0;
        repeat (20) cycle();
        check_output("tmo_not_early", cfg_n, 1);
        cycle();
        check_output("tmo_req_low", cfg_n, 0);
        check_output("tmo_status", int_status, 4'b0010);
        check_output("tmo_cnt", int_cnt, 1);
        rdy_n = 1'b0; cycle(); rdy_n = 1'b1;
        coal_timeout = '0; coal_thresh = 8'd1;

        // Legacy INTx: assert, deferred second event, host clear, deassert, re-fire
        sb_on = 1'b0;
        do_reset();
        msi_on = 1'b0;
        req_done = 4'b0001; cycle();
        req_done = '0; cycle();
        check_output("leg_assert_req", cfg_n, 0);
        check_output("leg_assert_sel", assert_n, 0);
        cycle(); cycle();
        rdy_n = 1'b0; cycle(); rdy_n = 1'b1;
        check_output("leg_asserted_cfg", cfg_n, 1);
        check_output("leg_asserted_sel", assert_n, 0);
        req_done = 4'b1000; cycle();
        req_done = '0;
        repeat (3) cycle();
        check_output("leg_deferred", cfg_n, 1);
        check_output("leg_deferred_cnt", int_cnt, 1);
        int_status_clr = 4'b1111; cycle();
        int_status_clr = '0;
        check_output("leg_cleared", int_status, 0);
        cycle();
        check_output("leg_deassert_req", cfg_n, 0);
        check_output("leg_deassert_sel", assert_n, 1);
        rdy_n = 1'b0; cycle(); rdy_n = 1'b1;
        check_output("leg_idle", cfg_n, 1);
        cycle();
        check_output("leg_refire", cfg_n, 0);
        check_output("leg_refire_sel", assert_n, 0);
        check_output("leg_refire_status", int_status, 4'b1000);
        check_output("leg_refire_cnt", int_cnt, 2);
        rdy_n = 1'b0; cycle(); rdy_n = 1'b1;
        legacyclr = 1'b1; cycle(); legacyclr = 1'b0;
        check_output("leg_lclr_deassert", cfg_n, 0);
        check_output("leg_lclr_sel", assert_n, 1);
        rdy_n = 1'b0; cycle(); rdy_n = 1'b1;
        check_output("leg_lclr_idle", cfg_n, 1);

        // Reset while ASSERTED
        do_reset();
        msi_on = 1'b0;
        req_done = 4'b0100; cycle();
        req_done = '0; cycle();
        rdy_n = 1'b0; cycle(); rdy_n = 1'b1;
        check_output("rst_pre_sel", assert_n, 0);
        rst = 1'b1; cycle(); rst = 1'b0;
        check_output("rst_mid_status", int_status, 0);
        check_output("rst_mid_cnt", int_cnt, 0);
        check_output("rst_mid_cfg_n", cfg_n, 1);
        check_output("rst_mid_assert_n", assert_n, 1);
        msi_on = 1'b1;
        sb_on = 1'b1;

        // Masked ch0 held high; ch1 toggles while the first request is outstanding,
        // so its later events batch into one follow-up interrupt
        do_reset();
        int_msk = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            req_done = {2'b00, (i < 8) && (i % 2 == 0), 1'b1};
            cycle();
        end
        req_done = '0; cycle();
        check_output("msk_pending", cfg_n, 0);
        check_output("msk_status", int_status, 4'b0010);
        check_output("msk_cnt1", int_cnt, 1);
        rdy_n = 1'b0; cycle(); rdy_n = 1'b1;
        check_output("msk_gap", cfg_n, 1);
        cycle();
        check_output("msk_second", cfg_n, 0);
        check_output("msk_cnt2", int_cnt, 2);
        rdy_n = 1'b0; cycle(); rdy_n = 1'b1;
        repeat (3) cycle();
        check_output("msk_no_more", int_cnt, 2);
        int_msk = '0;

        // en dropped during MSI_REQ
        do_reset();
        req_done = 4'b0100; cycle();
        req_done = '0; cycle();
        check_output("en_req_low", cfg_n, 0);
        en = 1'b0; cycle();
        check_output("en_req_held", cfg_n, 0);
        check_output("en_status_clr", int_status, 0);
        req_done = 4'b0001; cycle();
        req_done = '0;
        rdy_n = 1'b0; cycle(); rdy_n = 1'b1;
        check_output("en_req_done", cfg_n, 1);
        repeat (3) cycle();
        check_output("en_no_fire", cfg_n, 1);
        check_output("en_cnt_kept", int_cnt, 1);
        en = 1'b1;

        // Randomized MSI traffic against the model
        do_reset();
        for (int c = 0; c < 4; c++) begin
            coal_thresh  = COAL_W'($urandom_range(0, 5));
            coal_timeout = (c % 2 == 1) ? TMR_W'($urandom_range(3, 30)) : '0;
            int_msk      = NUM_CH'($urandom_range(0, 15));
            repeat (300) begin
                apply_stimulus();
                cycle();
            end
        end
        req_done = '0; int_en = 1'b1; int_status_clr = '0; rdy_n = 1'b0;
        repeat (60) cycle();
        check_output("sb_drained", sb_q.size(), 0);
        check_output("final_cnt", int_cnt, m_cnt);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
